// File: rtl/minn_replay_pkg.sv
// Shared types, width helpers and default parameters for the Minn frame replay reader.
package minn_replay_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_MAX_LEN = 128;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/minn_replay_skid.sv
// Two-entry valid/ready output buffer for replayed samples; flush empties it in one cycle.
module minn_replay_skid
  import minn_replay_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic [1:0]              count
);

  logic [1:0]              cnt_q, cnt_d;
  logic signed [WIDTH-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
  logic                    lst0_q, lst0_d, lst1_q, lst1_d;
  logic                    pop;

  always_comb begin
    cnt_d  = cnt_q;
    dat0_d = dat0_q;
    dat1_d = dat1_q;
    lst0_d = lst0_q;
    lst1_d = lst1_q;
    pop    = (cnt_q != 2'd0) && out_ready;
    case ({in_valid, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          dat0_d = in_data;
          lst0_d = in_last;
        end else begin
          dat1_d = in_data;
          lst1_d = in_last;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        dat0_d = dat1_q;
        lst0_d = lst1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Head leaves while a new entry arrives; occupancy is unchanged.
        if (cnt_q == 2'd1) begin
          dat0_d = in_data;
          lst0_d = in_last;
        end else begin
          dat0_d = dat1_q;
          lst0_d = lst1_q;
          dat1_d = in_data;
          lst1_d = in_last;
        end
      end
      default: ;
    endcase
    if (flush) cnt_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      dat0_q <= '0;
      dat1_q <= '0;
      lst0_q <= 1'b0;
      lst1_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dat0_q <= dat0_d;
      dat1_q <= dat1_d;
      lst0_q <= lst0_d;
      lst1_q <= lst1_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = dat0_q;
  assign out_last  = lst0_q;
  assign count     = cnt_q;

endmodule

// File: rtl/minn_frame_replay.sv
// Minn sample history reader: replays len samples starting lag samples behind the write point.
// Define MINN_REPLAY_FRAME_COUNT_EN to enable the completed-frame counter on frame_count.
module minn_frame_replay
  import minn_replay_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     in_data,
  input  logic                        trig_valid,
  output logic                        trig_ready,
  input  logic [$clog2(DEPTH):0]      trig_lag,
  input  logic [$clog2(MAX_LEN):0]    trig_len,
  output logic                        trig_err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH-1:0]     out_data,
  output logic                        out_last,
  output logic                        overrun,
  output logic                        busy,
  output logic [15:0]                 frame_count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int LEN_W = len_w(MAX_LEN);

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic signed [WIDTH-1:0] rd_data_q;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d, avail_q, avail_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic             rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic             trig_err_q, trig_err_d, overrun_q, overrun_d;
  logic             issue, flush, pop, trig_bad;
  logic [1:0]       skid_cnt;
  logic [2:0]       occ;
  logic [CNT_W:0]   avail_nx;

  assign pop      = out_valid && out_ready;
  assign trig_bad = (trig_lag == '0) || (trig_lag > fill_q) ||
                    (trig_len == '0) || (trig_len > LEN_W'(MAX_LEN));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    rd_ptr_d   = rd_ptr_q;
    avail_d    = avail_q;
    remain_d   = remain_q;
    rd_vld_d   = 1'b0;
    rd_last_d  = rd_last_q;
    trig_err_d = 1'b0;
    overrun_d  = 1'b0;
    issue      = 1'b0;
    flush      = 1'b0;
    avail_nx   = '0;
    // Reads already in flight count against skid space so the buffer never overfills.
    occ        = 3'(skid_cnt) + 3'(rd_vld_q) - 3'(pop);

    if (in_valid) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != CNT_W'(DEPTH)) fill_d = fill_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trig_valid) begin
          avail_nx = {1'b0, trig_lag} + (CNT_W+1)'(in_valid);
          if (trig_bad) begin
            trig_err_d = 1'b1;
          end else if (avail_nx > (CNT_W+1)'(DEPTH)) begin
            // Oldest requested sample is overwritten on this very edge.
            overrun_d = 1'b1;
          end else begin
            state_d  = RUN;
            rd_ptr_d = wr_ptr_q - trig_lag[PTR_W-1:0];
            remain_d = trig_len;
            avail_d  = avail_nx[CNT_W-1:0];
          end
        end
      end
      RUN: begin
        issue    = (occ < 3'd2) && (avail_q != '0);
        avail_nx = {1'b0, avail_q} + (CNT_W+1)'(in_valid) - (CNT_W+1)'(issue);
        if (avail_nx > (CNT_W+1)'(DEPTH)) begin
          overrun_d = 1'b1;
          flush     = 1'b1;
          state_d   = IDLE;
        end else begin
          avail_d = avail_nx[CNT_W-1:0];
          if (issue) begin
            rd_vld_d  = 1'b1;
            rd_last_d = (remain_q == LEN_W'(1));
            rd_ptr_d  = rd_ptr_q + 1'b1;
            remain_d  = remain_q - 1'b1;
            if (remain_q == LEN_W'(1)) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_valid) mem[wr_ptr_q] <= in_data;
    if (issue) rd_data_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      rd_ptr_q   <= '0;
      avail_q    <= '0;
      remain_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      trig_err_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      rd_ptr_q   <= rd_ptr_d;
      avail_q    <= avail_d;
      remain_q   <= remain_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      trig_err_q <= trig_err_d;
      overrun_q  <= overrun_d;
    end
  end

  minn_replay_skid #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (rd_vld_q),
    .in_data   (rd_data_q),
    .in_last   (rd_last_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (skid_cnt)
  );

`ifdef MINN_REPLAY_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (pop && out_last) frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_count_q <= '0;
    else        frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = '0;
`endif

  assign trig_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign trig_err   = trig_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_minn_frame_replay.sv
// Scoreboard bench for minn_frame_replay: stimulus queues expected samples, a monitor checks transfers.
module tb_minn_frame_replay;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 256;
  localparam int MAX_LEN = 128;
  localparam int LAG_W   = $clog2(DEPTH) + 1;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    in_valid, trig_valid, out_ready;
  logic signed [WIDTH-1:0] in_data;
  logic [LAG_W-1:0]        trig_lag;
  logic [LEN_W-1:0]        trig_len;
  logic                    trig_ready, trig_err, out_valid, out_last, overrun, busy;
  logic signed [WIDTH-1:0] out_data;
  logic [15:0]             frame_count;

  minn_frame_replay #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .trig_valid  (trig_valid),
    .trig_ready  (trig_ready),
    .trig_lag    (trig_lag),
    .trig_len    (trig_len),
    .trig_err    (trig_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .overrun     (overrun),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  exp_t             exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, i.e. the transfer about to happen on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !overrun) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got data %0d, expected no output", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_last", 32'(out_last), 32'(e.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_n(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(first + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_frame(input int first, input int len);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.data = WIDTH'(first + i);
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic trigger(input int lag, input int len);
    trig_valid = 1'b1;
    trig_lag   = LAG_W'(lag);
    trig_len   = LEN_W'(len);
    tick();
    trig_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, input bit rnd);
    int c = 0;
    while ((busy || exp_q.size() != 0) && c < budget) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    out_ready = 1'b1;
    check({name, "_complete"}, 32'(busy == 1'b0 && exp_q.size() == 0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen;
    logic [15:0] fc0;
    in_valid = 1'b0; in_data = '0; trig_valid = 1'b0;
    trig_lag = '0; trig_len = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_trig_ready", 32'(trig_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_trig_err", 32'(trig_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic replay: 13..20, latency 2, back-to-back samples.
    write_n(1, 20);
    expect_frame(13, 8);
    trigger(8, 8);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_lat_k", 32'(out_valid), 32'd0);
    tick();
    check("t1_lat_k1", 32'(out_valid), 32'd0);
    tick();
    check("t1_first_valid", 32'(out_valid), 32'd1);
    check("t1_first_data", 32'(out_data), 32'd13);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("t1_stream_valid", 32'(out_valid), 32'd1);
    end
    wait_idle("t1", 50, 1'b0);
    check("t1_trig_ready", 32'(trig_ready), 32'd1);

    // Rejected requests.
    do_reset();
    write_n(1, 10);
    trigger(11, 4);
    check("t2_err_lag", 32'(trig_err), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    tick();
    check("t2_err_pulse", 32'(trig_err), 32'd0);
    trigger(5, 0);
    check("t2_err_len0", 32'(trig_err), 32'd1);
    tick();
    tick();
    check("t2_no_valid", 32'(out_valid), 32'd0);
    check("t2_idle", 32'(busy), 32'd0);

    // Full-depth lag across pointer wrap.
    do_reset();
    write_n(1, 300);
    expect_frame(45, 4);
    trigger(256, 4);
    wait_idle("t3", 50, 1'b0);

    // Reader catches writer, stalls, resumes on new input.
    do_reset();
    write_n(1, 10);
    expect_frame(7, 8);
    trigger(4, 8);
    repeat (10) tick();
    check("t4_stall_valid", 32'(out_valid), 32'd0);
    check("t4_stall_busy", 32'(busy), 32'd1);
    check("t4_stall_left", 32'(exp_q.size()), 32'd4);
    write_n(11, 4);
    wait_idle("t4", 50, 1'b0);

    // Overrun while downstream is stalled.
    do_reset();
    write_n(1, 10);
    fc0 = frame_count;
    out_ready = 1'b0;
    trigger(4, 8);
    seen = 0;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(1000 + i);
      tick();
      if (overrun) seen = 1;
    end
    in_valid = 1'b0;
    check("t5_overrun_seen", 32'(seen), 32'd1);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    tick();
    check("t5_overrun_pulse", 32'(overrun), 32'd0);
    check("t5_frame_count", 32'(frame_count), 32'(fc0));
    check("t5_trig_ready", 32'(trig_ready), 32'd1);
    out_ready = 1'b1;

    // Random backpressure over a long frame, then reset mid-frame.
    do_reset();
    write_n(1, 100);
    expect_frame(37, 64);
    trigger(64, 64);
    wait_idle("t6", 2000, 1'b1);
`ifdef MINN_REPLAY_FRAME_COUNT_EN
    check("t6_frame_count", 32'(frame_count), 32'd1);
`else
    check("t6_frame_count", 32'(frame_count), 32'd0);
`endif
    expect_frame(93, 8);
    trigger(8, 8);
    tick();
    tick();
    tick();
    check("t7_valid_before_rst", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_out_valid", 32'(out_valid), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_trig_ready", 32'(trig_ready), 32'd1);
    check("t7_rst_frame_count", 32'(frame_count), 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    trigger(1, 1);
    check("t7_empty_history_err", 32'(trig_err), 32'd1);
    tick();
    check("t7_no_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
